// File: rtl/sprite_tex_loader.sv
// sprite_tex_loader
//
// Purpose: after a start pulse, fetch the bird sprite sheet and then the pipe
// texture from SDRAM in bursts of at most BURST_LEN words. Each returned word
// is replayed one cycle later as a write strobe on the sprite renderer's
// texture-load ports. busy/done let the top level hold the game in its title
// state until both textures are resident. Everything runs in the 50 MHz
// load-clock domain.
//
// Configuration macro: PIPE_TRUNC_EN
//   defined   - the pipe phase loads only PIPE_TRUNC_WORDS (the 50-row
//               cap/loop section the renderer actually keeps)
//   undefined - the full PIPE_WORDS pipe texture is loaded
//
// Ports:
//   bird_load_clk   in   load clock, 50 MHz
//   rst_n           in   synchronous active-low reset
//   start           in   one-cycle pulse, begins a load sequence from IDLE
//   rd_req          out  SDRAM burst read request
//   rd_addr         out  [23:0] burst start word address
//   rd_len          out  [8:0]  burst length in words, 1..BURST_LEN
//   rd_ack          in   one-cycle pulse accepting the pending request
//   rd_valid        in   read data word valid
//   rd_data         in   [15:0] read data word
//   bird_load_en    out  bird RAM write strobe
//   bird_load_addr  out  [12:0] bird RAM write address
//   bird_load_data  out  [15:0] write data, shared by bird and pipe RAMs
//   pipe_load_en    out  pipe RAM write strobe
//   pipe_load_addr  out  [15:0] pipe RAM write address
//   busy            out  high from start acceptance until the final write
//   done            out  sticky completion flag, cleared by start or reset

module sprite_tex_loader #(
  parameter logic [23:0] BIRD_BASE        = 24'h000000,
  parameter int          BIRD_WORDS       = 5250,
  parameter logic [23:0] PIPE_BASE        = 24'h002000,
  parameter int          PIPE_WORDS       = 40000,
  parameter int          PIPE_TRUNC_WORDS = 4000,
  parameter int          BURST_LEN        = 256
) (
  input  logic        bird_load_clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  output logic [8:0]  rd_len,
  input  logic        rd_ack,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic        bird_load_en,
  output logic [12:0] bird_load_addr,
  output logic [15:0] bird_load_data,
  output logic        pipe_load_en,
  output logic [15:0] pipe_load_addr,
  output logic        busy,
  output logic        done
);

  // Word totals per region. The truncated pipe load can never exceed the
  // full texture, and the full load always covers at least the truncated part.
  localparam logic [15:0] BIRD_TOTAL = 16'(BIRD_WORDS);
`ifdef PIPE_TRUNC_EN
  localparam logic [15:0] PIPE_TOTAL =
    16'((PIPE_TRUNC_WORDS < PIPE_WORDS) ? PIPE_TRUNC_WORDS : PIPE_WORDS);
`else
  localparam logic [15:0] PIPE_TOTAL =
    16'((PIPE_WORDS > PIPE_TRUNC_WORDS) ? PIPE_WORDS : PIPE_TRUNC_WORDS);
`endif
  localparam logic [15:0] BURST_LEN_W = 16'(BURST_LEN);
  localparam logic [8:0]  BURST_LEN_L = 9'(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    BIRD_REQ,
    BIRD_DATA,
    PIPE_REQ,
    PIPE_DATA,
    DONE
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [15:0] cnt;
  logic [8:0]  bcnt;

  logic        in_bird;
  logic        in_data;
  logic [15:0] total;
  logic [15:0] remaining;
  logic [8:0]  req_len;
  logic [23:0] req_base;
  logic        accept;
  logic [15:0] cnt_inc;
  logic [15:0] words_after;
  logic        burst_end;
  logic        region_end;
  logic        ack_taken;

  // Region selection, request shaping and burst bookkeeping.
  // A burst ends either on its last accepted word, so the next request can
  // follow immediately, or if the burst counter is already empty.
  always_comb begin
    in_bird     = (state == BIRD_REQ) || (state == BIRD_DATA);
    in_data     = (state == BIRD_DATA) || (state == PIPE_DATA);
    total       = in_bird ? BIRD_TOTAL : PIPE_TOTAL;
    req_base    = in_bird ? BIRD_BASE : PIPE_BASE;
    remaining   = total - cnt;
    req_len     = (remaining >= BURST_LEN_W) ? BURST_LEN_L : remaining[8:0];
    accept      = in_data && rd_valid && (bcnt != 9'd0);
    cnt_inc     = cnt + 16'd1;
    words_after = accept ? cnt_inc : cnt;
    burst_end   = in_data && ((bcnt == 9'd0) || (accept && (bcnt == 9'd1)));
    region_end  = (words_after >= total);
    ack_taken   = rd_req && rd_ack;
  end

  // State register.
  always_ff @(posedge bird_load_clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. start outside IDLE is ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = BIRD_REQ;
      BIRD_REQ:  if (ack_taken) next_state = BIRD_DATA;
      BIRD_DATA: if (burst_end) next_state = region_end ? PIPE_REQ : BIRD_REQ;
      PIPE_REQ:  if (ack_taken) next_state = PIPE_DATA;
      PIPE_DATA: if (burst_end) next_state = region_end ? DONE : PIPE_REQ;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Registered outputs and counters. The request is raised one cycle after
  // entering a REQ state and its address/length are recomputed from an
  // unchanging cnt, so they stay stable until the ack. Write strobes carry
  // their address and data in the same register stage.
  always_ff @(posedge bird_load_clk) begin
    if (!rst_n) begin
      rd_req         <= 1'b0;
      rd_addr        <= '0;
      rd_len         <= '0;
      bird_load_en   <= 1'b0;
      bird_load_addr <= '0;
      bird_load_data <= '0;
      pipe_load_en   <= 1'b0;
      pipe_load_addr <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cnt            <= '0;
      bcnt           <= '0;
    end else begin
      bird_load_en <= 1'b0;
      pipe_load_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            done <= 1'b0;
            cnt  <= '0;
          end
        end
        BIRD_REQ, PIPE_REQ: begin
          if (ack_taken) begin
            rd_req <= 1'b0;
            bcnt   <= rd_len;
          end else begin
            rd_req  <= 1'b1;
            rd_addr <= req_base + {8'd0, cnt};
            rd_len  <= req_len;
          end
        end
        BIRD_DATA, PIPE_DATA: begin
          if (accept) begin
            bird_load_data <= rd_data;
            if (state == BIRD_DATA) begin
              bird_load_en   <= 1'b1;
              bird_load_addr <= cnt[12:0];
            end else begin
              pipe_load_en   <= 1'b1;
              pipe_load_addr <= cnt;
            end
            bcnt <= bcnt - 9'd1;
            cnt  <= cnt_inc;
          end
          // The pipe region counts its words from zero again.
          if ((state == BIRD_DATA) && burst_end && region_end) begin
            cnt <= '0;
          end
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_tex_loader.sv
// tb_sprite_tex_loader
//
// Purpose: directed self-checking bench for sprite_tex_loader. A small SDRAM
// model acks each request three cycles after seeing it and streams the burst,
// optionally with random gaps and stray words during the request phase. A
// strobe monitor checks every write address/data against the model contents.
// The loader is built with reduced region sizes (bird 600 = 2x256+88,
// pipe 700 = 2x256+188, truncated pipe 300 = 256+44) and a pipe base close to
// the top of the address space so the 24-bit address wrap is exercised.
//
// Ports: none (top-level bench).

module tb_sprite_tex_loader;

  localparam logic [23:0] BIRD_BASE        = 24'h000010;
  localparam int          BIRD_WORDS       = 600;
  localparam logic [23:0] PIPE_BASE        = 24'hFFFF80;
  localparam int          PIPE_WORDS       = 700;
  localparam int          PIPE_TRUNC_WORDS = 300;
  localparam int          BURST_LEN        = 256;

`ifdef PIPE_TRUNC_EN
  localparam int PIPE_EXP = PIPE_TRUNC_WORDS;
  localparam int N_REQ    = 5;
`else
  localparam int PIPE_EXP = PIPE_WORDS;
  localparam int N_REQ    = 6;
`endif

  logic        bird_load_clk;
  logic        rst_n;
  logic        start;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic [8:0]  rd_len;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        bird_load_en;
  logic [12:0] bird_load_addr;
  logic [15:0] bird_load_data;
  logic        pipe_load_en;
  logic [15:0] pipe_load_addr;
  logic        busy;
  logic        done;

  int          checks;
  int          errors;
  int          bird_strobes;
  int          pipe_strobes;
  int          last_pipe_addr;
  bit          gap_mode;
  int          stray_left;
  bit          model_busy;
  logic [23:0] req_addr_q[$];
  logic [8:0]  req_len_q[$];
  logic [23:0] exp_addr[0:5];
  logic [8:0]  exp_len[0:5];

  sprite_tex_loader #(
    .BIRD_BASE       (BIRD_BASE),
    .BIRD_WORDS      (BIRD_WORDS),
    .PIPE_BASE       (PIPE_BASE),
    .PIPE_WORDS      (PIPE_WORDS),
    .PIPE_TRUNC_WORDS(PIPE_TRUNC_WORDS),
    .BURST_LEN       (BURST_LEN)
  ) dut (
    .bird_load_clk (bird_load_clk),
    .rst_n         (rst_n),
    .start         (start),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_len        (rd_len),
    .rd_ack        (rd_ack),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .bird_load_en  (bird_load_en),
    .bird_load_addr(bird_load_addr),
    .bird_load_data(bird_load_data),
    .pipe_load_en  (pipe_load_en),
    .pipe_load_addr(pipe_load_addr),
    .busy          (busy),
    .done          (done)
  );

  // 50 MHz load clock.
  initial bird_load_clk = 1'b0;
  always #10 bird_load_clk = ~bird_load_clk;

  // SDRAM contents: a fixed scramble of the word address.
  function automatic logic [15:0] memWord(input logic [23:0] a);
    return {a[7:0], a[15:8]} ^ {a[23:16], 8'h3C};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_rd_req", 32'(rd_req), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_rd_len", 32'(rd_len), 32'd0);
    checkOutput("rst_bird_en", 32'(bird_load_en), 32'd0);
    checkOutput("rst_bird_addr", 32'(bird_load_addr), 32'd0);
    checkOutput("rst_load_data", 32'(bird_load_data), 32'd0);
    checkOutput("rst_pipe_en", 32'(pipe_load_en), 32'd0);
    checkOutput("rst_pipe_addr", 32'(pipe_load_addr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
  endtask

  // Clears the bookkeeping, configures the model and pulses start, then
  // checks busy/done and the first request timing.
  task automatic applyStimulus(input bit gaps, input int strays);
    req_addr_q.delete();
    req_len_q.delete();
    bird_strobes   = 0;
    pipe_strobes   = 0;
    last_pipe_addr = -1;
    gap_mode       = gaps;
    stray_left     = strays;
    start = 1'b1;
    @(negedge bird_load_clk);
    start = 1'b0;
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_done_clr", 32'(done), 32'd0);
    checkOutput("req_not_yet", 32'(rd_req), 32'd0);
    @(negedge bird_load_clk);
    checkOutput("first_req", 32'(rd_req), 32'd1);
    checkOutput("first_addr", 32'(rd_addr), 32'(BIRD_BASE));
    checkOutput("first_len", 32'(rd_len), 32'd256);
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge bird_load_clk);
      n++;
    end
    checkOutput("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic checkRun();
    checkOutput("bird_strobes", 32'(bird_strobes), 32'(BIRD_WORDS));
    checkOutput("pipe_strobes", 32'(pipe_strobes), 32'(PIPE_EXP));
    checkOutput("last_pipe_addr", 32'(last_pipe_addr), 32'(PIPE_EXP - 1));
    checkOutput("req_count", 32'(req_addr_q.size()), 32'(N_REQ));
    for (int i = 0; i < N_REQ && i < req_addr_q.size(); i++) begin
      checkOutput($sformatf("req_addr[%0d]", i), 32'(req_addr_q[i]), 32'(exp_addr[i]));
      checkOutput($sformatf("req_len[%0d]", i), 32'(req_len_q[i]), 32'(exp_len[i]));
    end
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("end_done", 32'(done), 32'd1);
  endtask

  // Strobe monitor: exclusivity, sequential addresses and data per region.
  always @(posedge bird_load_clk) begin
    #1;
    if (bird_load_en === 1'b1 || pipe_load_en === 1'b1) begin
      checkOutput("en_exclusive", 32'(bird_load_en & pipe_load_en), 32'd0);
    end
    if (bird_load_en === 1'b1) begin
      checkOutput("bird_addr", 32'(bird_load_addr), 32'(bird_strobes));
      checkOutput("bird_data", 32'(bird_load_data),
                  32'(memWord(BIRD_BASE + 24'(bird_strobes))));
      bird_strobes++;
    end
    if (pipe_load_en === 1'b1) begin
      checkOutput("pipe_addr", 32'(pipe_load_addr), 32'(pipe_strobes));
      checkOutput("pipe_data", 32'(bird_load_data),
                  32'(memWord(PIPE_BASE + 24'(pipe_strobes))));
      last_pipe_addr = int'(pipe_load_addr);
      pipe_strobes++;
    end
  end

  // SDRAM read-port model, driven on the falling edge.
  initial begin
    logic [23:0] base;
    logic [8:0]  len;
    int          sent;
    rd_ack     = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    model_busy = 1'b0;
    forever begin
      @(negedge bird_load_clk);
      if (rd_req === 1'b1) begin
        model_busy = 1'b1;
        base = rd_addr;
        len  = rd_len;
        for (int w = 0; w < 2; w++) begin
          if (stray_left > 0) begin
            rd_valid = 1'b1;
            rd_data  = 16'hDEAD;
            stray_left--;
          end else begin
            rd_valid = 1'b0;
          end
          @(negedge bird_load_clk);
        end
        rd_valid = 1'b0;
        rd_ack   = 1'b1;
        req_addr_q.push_back(base);
        req_len_q.push_back(len);
        @(negedge bird_load_clk);
        rd_ack = 1'b0;
        sent   = 0;
        while (sent < int'(len)) begin
          if (gap_mode && $urandom_range(1) == 0) begin
            rd_valid = 1'b0;
          end else begin
            rd_valid = 1'b1;
            rd_data  = memWord(base + 24'(sent));
            sent++;
          end
          @(negedge bird_load_clk);
        end
        rd_valid   = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  // Directed sequence.
  initial begin
    int n;
    int snap_bird;
    int snap_pipe;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    gap_mode   = 1'b0;
    stray_left = 0;
    exp_addr[0] = 24'h000010; exp_len[0] = 9'd256;
    exp_addr[1] = 24'h000110; exp_len[1] = 9'd256;
    exp_addr[2] = 24'h000210; exp_len[2] = 9'd88;
    exp_addr[3] = 24'hFFFF80; exp_len[3] = 9'd256;
`ifdef PIPE_TRUNC_EN
    exp_addr[4] = 24'h000080; exp_len[4] = 9'd44;
    exp_addr[5] = 24'h000000; exp_len[5] = 9'd0;
`else
    exp_addr[4] = 24'h000080; exp_len[4] = 9'd256;
    exp_addr[5] = 24'h000180; exp_len[5] = 9'd188;
`endif

    repeat (3) @(negedge bird_load_clk);
    $display("[TB] reset values");
    checkResetOutputs();
    rst_n = 1'b1;
    @(negedge bird_load_clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] contiguous load with start pulsed while busy");
    applyStimulus(1'b0, 0);
    n = 0;
    while (bird_strobes < 300 && n < 2000) begin
      @(negedge bird_load_clk);
      n++;
    end
    checkOutput("mid_bird_reached", 32'(bird_strobes >= 300), 32'd1);
    start = 1'b1;
    @(negedge bird_load_clk);
    start = 1'b0;
    checkOutput("busy_start_busy", 32'(busy), 32'd1);
    checkOutput("busy_start_addr", 32'(rd_addr), 32'h000110);
    repeat (2) @(negedge bird_load_clk);
    checkOutput("busy_start_addr2", 32'(rd_addr), 32'h000110);
    checkOutput("busy_start_done", 32'(done), 32'd0);
    waitDone(5000);
    checkRun();

    $display("[TB] gapped load with stray words");
    applyStimulus(1'b1, 2);
    waitDone(10000);
    checkRun();
    checkOutput("strays_consumed", 32'(stray_left), 32'd0);

    $display("[TB] reset mid pipe burst");
    applyStimulus(1'b0, 0);
    n = 0;
    while (pipe_strobes < 100 && n < 3000) begin
      @(negedge bird_load_clk);
      n++;
    end
    checkOutput("mid_pipe_reached", 32'(pipe_strobes >= 100), 32'd1);
    rst_n = 1'b0;
    @(negedge bird_load_clk);
    checkResetOutputs();
    snap_bird = bird_strobes;
    snap_pipe = pipe_strobes;
    repeat (2) @(negedge bird_load_clk);
    rst_n = 1'b1;
    n = 0;
    while (model_busy && n < 1000) begin
      @(negedge bird_load_clk);
      n++;
    end
    checkOutput("leftover_drained", 32'(model_busy), 32'd0);
    repeat (3) @(negedge bird_load_clk);
    checkOutput("leftover_bird", 32'(bird_strobes), 32'(snap_bird));
    checkOutput("leftover_pipe", 32'(pipe_strobes), 32'(snap_pipe));
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_req", 32'(rd_req), 32'd0);

    $display("[TB] rerun after reset");
    applyStimulus(1'b0, 0);
    waitDone(5000);
    checkRun();

    repeat (5) @(negedge bird_load_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_tex_loader.md
# sprite_tex_loader

- Fetches the bird sprite sheet and the pipe texture from SDRAM in bursts after a start pulse.
- Replays each fetched word as a one-cycle write strobe on the sprite renderer's texture-load ports.
- Sits between the SDRAM controller's read port and the sprite renderer, all in the 50 MHz load-clock domain.
- Signals `busy`/`done` so the top level can hold the game in its title state until the textures are resident.

## Interface
Parameters:
- `BIRD_BASE`, 24'h000000: SDRAM word address of bird texture word 0.
- `BIRD_WORDS`, 5250: bird words to load (3 frames × 50×35).
- `PIPE_BASE`, 24'h002000: SDRAM word address of pipe texture word 0.
- `PIPE_WORDS`, 40000: full pipe texture size (80×500).
- `PIPE_TRUNC_WORDS`, 4000: pipe words loaded when truncation is enabled (80×50).
- `BURST_LEN`, 256: maximum words per SDRAM read request.

Ports:
- `bird_load_clk` in 1: clock, 50 MHz.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse that begins a load sequence.
- `rd_req` out 1: SDRAM burst read request.
- `rd_addr` out 24: burst start word address.
- `rd_len` out 9: burst length in words, 1..`BURST_LEN`.
- `rd_ack` in 1: one-cycle pulse accepting the pending request.
- `rd_valid` in 1: read data word valid.
- `rd_data` in 16: read data word.
- `bird_load_en` out 1: bird RAM write strobe.
- `bird_load_addr` out 13: bird RAM write address.
- `bird_load_data` out 16: write data, shared by the bird and pipe RAMs.
- `pipe_load_en` out 1: pipe RAM write strobe.
- `pipe_load_addr` out 16: pipe RAM write address.
- `busy` out 1: high from `start` acceptance until the final word has been written.
- `done` out 1: sticky; high after a complete load, cleared by the next accepted `start` or by reset.

## Operation
State machine: IDLE → BIRD_REQ → BIRD_DATA → (BIRD_REQ | PIPE_REQ) → PIPE_DATA → (PIPE_REQ | DONE) → IDLE.

- **IDLE:** `start` high → `busy`=1, `done`=0, word counter `cnt`=0, go to BIRD_REQ.
  - `start` in any other state is ignored.
- **BIRD_REQ / PIPE_REQ:**
  - `rd_req`=1, `rd_addr`=base+`cnt`, `rd_len`=min(`BURST_LEN`, total−`cnt`).
  - `rd_addr` and `rd_len` are held stable until `rd_ack`.
  - `rd_ack` → `rd_req` drops the same edge, burst counter `bcnt` is loaded with `rd_len`, go to the matching DATA state.
- **BIRD_DATA / PIPE_DATA:**
  - Each `rd_valid` cycle: write strobe with address=`cnt`, data=`rd_data`; then `cnt`+1, `bcnt`−1.
  - `rd_valid` may be non-contiguous.
  - When `bcnt` reaches 0:
    - if `cnt`<total → back to the REQ state;
    - else bird → PIPE_REQ with `cnt`=0;
    - else pipe → DONE.
- **DONE:** `busy`=0, `done`=1 for one cycle of state, then IDLE. `done` stays high after leaving DONE.
- **Strays:** `rd_valid` outside a DATA state, or extra words after `bcnt`=0, are dropped with no strobe.
- **Width rules:**
  - `cnt` is 16 bit.
  - `rd_addr` = base + zero-extended `cnt`, modulo 2^24.
  - `bird_load_addr` = `cnt[12:0]`.
  - Only the final burst of each region is short: 5250 = 20×256+130; 40000 = 156×256+64; 4000 = 15×256+160.

## Timing
- **Reset values:**
  - `rd_req`, `bird_load_en`, `pipe_load_en`, `busy`, `done` = 0.
  - `rd_addr`, `rd_len`, `bird_load_addr`, `pipe_load_addr`, `bird_load_data` = 0.
  - State = IDLE.
- **Write latency:** 1 cycle from `rd_valid` to the strobe. Address and data are registered together with the strobe.
- **Enable exclusivity:** `bird_load_en` and `pipe_load_en` are never high together.
- **Request timing:**
  - `rd_req` rises the cycle after entering a REQ state.
  - After the last word of a burst, the next `rd_req` is asserted within 2 cycles.
- **`start` timing:**
  - `busy` rises the cycle after `start`.
  - `busy` falls the cycle after the last strobe.
- **Reset mid-operation:** all outputs return to reset values on the next edge. An SDRAM burst already in flight is discarded, because any `rd_valid` arriving in IDLE is ignored.

## Configuration
- `PIPE_TRUNC_EN` defined:
  - The pipe phase fetches only `PIPE_TRUNC_WORDS` (4000), i.e. the 50-row cap/loop section held in the renderer's pipe RAM.
  - Pipe load time drops about 10×.
- Undefined:
  - The full `PIPE_WORDS` (40000) are fetched and strobed with `pipe_load_addr` 0..39999.
  - The renderer discards addresses ≥4000.

## Test plan
1. Reset, then `start`, SDRAM model acking after 3 cycles and streaming contiguously.
   - Exactly 5250 `bird_load_en` pulses with addresses 0..5249 and data equal to the model's contents.
   - Then the pipe strobes.
   - `done`=1, `busy`=0 at the end.
2. Burst shape.
   - Bird requests: 21 requests, `rd_addr` stepping by 256 from `BIRD_BASE`, final `rd_len`=130.
   - `PIPE_TRUNC_EN` defined: 16 pipe requests, final `rd_len`=160, last `pipe_load_addr`=3999.
3. `PIPE_TRUNC_EN` undefined: 157 pipe requests, final `rd_len`=64, 40000 strobes, last address 39999.
4. `rd_valid` randomly deasserted ~50% of cycles, plus 2 stray words injected while in a REQ state.
   - Strobe count and addresses unchanged.
   - No strobe for the stray words.
5. Reset asserted mid pipe burst, then `start` again.
   - All outputs 0 the cycle after reset.
   - Leftover `rd_valid` words are ignored.
   - The rerun completes with correct counts.
6. `start` pulsed while `busy`: ignored, with no restart and no change to `cnt` or `rd_addr`.
